// File: rtl/wash_pkg.sv
// wash_pkg: shared state, mode and digit encodings for the wash setup front end
package wash_pkg;
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    SELECT = 3'd1,
    RUN    = 3'd2,
    PAUSE  = 3'd3,
    DONE   = 3'd4
  } state_t;
  localparam logic [1:0] M_DRY   = 2'b00;
  localparam logic [1:0] M_SMALL = 2'b01;
  localparam logic [1:0] M_MED   = 2'b10;
  localparam logic [1:0] M_LARGE = 2'b11;
  localparam logic [3:0] BLANK   = 4'd11;
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    tens_of = 4'd0;
    for (int i = 1; i < 10; i++)
      if (v >= 7'(10 * i)) tens_of = 4'(i);
  endfunction
endpackage

// File: rtl/wash_setup_if.sv
// wash_setup_if: button, controller handshake and display signals of the setup front end
interface wash_setup_if;
  logic       on;
  logic       bt_mode;
  logic       bt_start;
  logic       done_i;
  logic [1:0] mode;
  logic       start_o;
  logic       hold_o;
  logic [6:0] total_sec;
  logic [3:0] dig_mode;
  logic [3:0] dig_tens;
  logic [3:0] dig_ones;
  logic [2:0] state_o;
  modport master (
    input  on, bt_mode, bt_start, done_i,
    output mode, start_o, hold_o, total_sec, dig_mode, dig_tens, dig_ones, state_o
  );
  modport slave (
    output on, bt_mode, bt_start, done_i,
    input  mode, start_o, hold_o, total_sec, dig_mode, dig_tens, dig_ones, state_o
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button and emits one pulse per accepted press
module btn_debounce #(
  parameter int DB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic s1, s2, lvl, hit;
  logic [CW-1:0] cnt;
  assign hit = (s2 != lvl) && (cnt == CW'(DB_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= hit && s2;
      if (hit) lvl <= s2;
      cnt   <= (s2 == lvl || hit) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/wash_setup.sv
// wash_setup: program selection FSM with debounced buttons and setup-screen digits
module wash_setup
  import wash_pkg::*;
#(
  parameter int DB_CYCLES = 2000000,
  parameter int T_DRY     = 20,
  parameter int T_SMALL   = 60,
  parameter int T_MED     = 80,
  parameter int T_LARGE   = 99
) (
  input logic         clk,
  input logic         rst,
  wash_setup_if.master bus
);
  logic mode_p, start_p, start_n, start_r, hold_r;
  logic [1:0] mode, mode_n;
  logic [6:0] total;
  logic [3:0] tens;
  state_t state, nxt;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .raw(bus.bt_mode), .pulse(mode_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk(clk), .rst(rst), .raw(bus.bt_start), .pulse(start_p)
  );
  always_comb begin
    nxt     = state;
    mode_n  = mode;
    start_n = 1'b0;
    case (state)
      OFF:    nxt = SELECT;
      SELECT: begin
        nxt     = start_p ? RUN : SELECT;
        start_n = start_p;
        mode_n  = (mode_p && !start_p) ? mode + 2'd1 : mode;
      end
      RUN:    nxt = bus.done_i ? DONE : start_p ? PAUSE : RUN;
      PAUSE:  nxt = start_p ? RUN : PAUSE;
      DONE:   nxt = (mode_p || start_p) ? SELECT : DONE;
      default: nxt = OFF;
    endcase
    if (!bus.on) begin
      nxt     = OFF;
      mode_n  = mode;
      start_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OFF;
      mode    <= M_SMALL;
      start_r <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      state   <= nxt;
      mode    <= mode_n;
      start_r <= start_n;
      hold_r  <= nxt == PAUSE;
    end
  end
  always_comb begin
    total = mode == M_DRY   ? 7'(T_DRY)   :
            mode == M_SMALL ? 7'(T_SMALL) :
            mode == M_MED   ? 7'(T_MED)   : 7'(T_LARGE);
    tens  = tens_of(total);
  end
  assign bus.mode      = mode;
  assign bus.start_o   = start_r;
  assign bus.hold_o    = hold_r;
  assign bus.total_sec = total;
  assign bus.state_o   = state;
  assign bus.dig_mode  = state == OFF ? BLANK : {2'b00, mode};
  assign bus.dig_tens  = state == OFF ? BLANK : tens;
  assign bus.dig_ones  = state == OFF ? BLANK : 4'(total - 7'(tens) * 7'd10);
endmodule

// File: doc/wash_setup.md
Name: wash_setup

Overview:
- Upstream program-selection front end for the wash controller.
- Debounces the raw mode and start/pause buttons and holds the selected program: 00 spin-only, 01 small, 10 medium, 11 large.
- Issues a one-cycle start pulse and a pause hold level, and tracks run/pause/done.
- Drives setup-screen digits (program number, preset seconds) in the 4-bit digit code the display scanner consumes (0-9 digits, 11 blank).

Parameters:
- DB_CYCLES, 2000000, stable-level cycles required to accept a button edge (20 ms at 100 MHz).
- T_DRY, 20, preset seconds for mode 00.
- T_SMALL, 60, preset seconds for mode 01.
- T_MED, 80, preset seconds for mode 10.
- T_LARGE, 99, preset seconds for mode 11; all presets must be ≤ 99.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- on  in  1  power switch level
- bt_mode  in  1  raw mode button, asynchronous, active-high
- bt_start  in  1  raw start/pause button, asynchronous, active-high
- done_i  in  1  one-cycle pulse from wash controller: program finished
- mode  out  2  selected program, stable outside SELECT
- start_o  out  1  one-cycle pulse, begin program
- hold_o  out  1  high while paused; wash controller freezes its timers
- total_sec  out  7  preset seconds of current mode
- dig_mode  out  4  digit code: mode value 0-3, or 11 when OFF
- dig_tens  out  4  total_sec/10, or 11 when OFF
- dig_ones  out  4  total_sec%10, or 11 when OFF
- state_o  out  3  current FSM state, for status LEDs

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is synchronous, active-high, and dominant over every other input.
  - Reset values: state=OFF, mode=01, start_o=0, hold_o=0, total_sec=T_SMALL, digits=11, state_o=OFF.
- Button front end:
  - Each raw button is double-flop synchronised.
  - A level change is accepted only after DB_CYCLES consecutive equal samples.
  - Accepted 0→1 transition produces a one-cycle press pulse (mode_p, start_p).
  - Latency from raw edge: 2 + DB_CYCLES cycles.
  - Release generates nothing; a held button gives exactly one pulse.
- FSM states (encoding in package): OFF=0, SELECT=1, RUN=2, PAUSE=3, DONE=4.
  - OFF: on=1 → SELECT next cycle; mode keeps its value.
  - SELECT:
    - mode_p → mode = mode+1, wrapping 11→00.
    - start_p → RUN, with start_o=1 for exactly the transition cycle.
    - mode_p and start_p in the same cycle: start wins; mode is not advanced.
  - RUN:
    - start_p → PAUSE.
    - done_i → DONE.
    - done_i and start_p in the same cycle: done wins.
    - mode_p ignored.
  - PAUSE:
    - hold_o=1 (registered, asserted the cycle the state becomes PAUSE).
    - start_p → RUN, hold_o drops the same cycle state leaves PAUSE.
    - done_i ignored in PAUSE.
  - DONE: any press pulse → SELECT; mode unchanged.
  - Any state: on=0 → OFF next cycle. start_o and hold_o are 0 in OFF, and a pending pulse is dropped.
- Outputs and arithmetic:
  - total_sec is a combinational lookup of mode via registered mode; it changes one cycle after mode_p.
  - Digit split uses constant-compare or lookup, not a generic divider: tens = total_sec≥90?9 : ≥80?8 …; ones = total_sec − 10·tens; 7-bit arithmetic.
  - start_o never asserts outside the SELECT→RUN transition; never two consecutive cycles.

Decomposition:
- Package wash_pkg:
  - state encoding constants (OFF..DONE);
  - mode constants (M_DRY=00, M_SMALL=01, M_MED=10, M_LARGE=11);
  - digit code BLANK=4'd11.
- One sub-module btn_debounce:
  - Ports: clk, rst, raw, pulse.
  - Parameter DB_CYCLES; counter width $clog2(DB_CYCLES+1).
  - Instantiated twice.

Test Plan (DB_CYCLES=4 in simulation):
- Reset then on=1 → state_o=SELECT next cycle; mode=01; total_sec=60; digits 1,6,0.
- Four mode presses (raw held 8 cycles each) → mode sequence 10,11,00,01; after the 00 press total_sec=20 with digits 0,2,0.
- Raw bt_mode glitch high for 3 cycles → no mode change. Held high 50 cycles → exactly one increment.
- In SELECT press start → start_o high exactly 1 cycle, state RUN. Press start → hold_o=1, state PAUSE. done_i pulse in PAUSE → still PAUSE. Press start → RUN, hold_o=0.
- In RUN, done_i pulse coincident with a start_p → state DONE, hold_o stays 0. Then mode press → SELECT with mode unchanged.
- on=0 during PAUSE → next cycle OFF, hold_o=0, digits all 11. rst asserted mid-RUN → all reset values next cycle, mode=01.
